// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared types and helpers for the dual-port line RAM.
//   rdw_mode_e  : cross-port read-during-write behaviour (old or new data)
//   dpr_state_e : controller state (CLEAR sweep, RUN)
//   merge_line  : per-bit select between a new and an old line; callers
//                 expand their per-word mask to a bit mask first.
// ---------------------------------------------------------------------------
package ram_pkg;

    typedef enum logic {
        RDW_OLD,
        RDW_NEW
    } rdw_mode_e;

    typedef enum logic {
        CLEAR,
        RUN
    } dpr_state_e;

    // Widest line the merge helper handles; lines are zero-extended into
    // this width and the result truncated back by the caller.
    localparam int MERGE_MAX_W = 1024;

    function automatic logic [MERGE_MAX_W-1:0] merge_line(
        input logic [MERGE_MAX_W-1:0] bit_mask,
        input logic [MERGE_MAX_W-1:0] new_line,
        input logic [MERGE_MAX_W-1:0] old_line
    );
        return (new_line & bit_mask) | (old_line & ~bit_mask);
    endfunction

endpackage

// File: rtl/dual_port_line_ram_if.sv
// ---------------------------------------------------------------------------
// dual_port_line_ram_if
// One access port of the line RAM.
//   en       : access request (read always, write per-word via we)
//   we       : per-word write enables
//   addr     : line address
//   data_in  : write line
//   data_out : read line
//   rd_valid : data_out holds the result of an accepted request
// master = requester, slave = RAM.
// ---------------------------------------------------------------------------
interface dual_port_line_ram_if #(
    parameter int N             = 32,
    parameter int WORDSPERLINE  = 2,
    parameter int ADDRESS_WIDTH = 10
);
    logic                             en;
    logic [WORDSPERLINE-1:0]          we;
    logic [ADDRESS_WIDTH-1:0]         addr;
    logic [WORDSPERLINE-1:0][N-1:0]   data_in;
    logic [WORDSPERLINE-1:0][N-1:0]   data_out;
    logic                             rd_valid;

    modport master (
        output en, we, addr, data_in,
        input  data_out, rd_valid
    );

    modport slave (
        input  en, we, addr, data_in,
        output data_out, rd_valid
    );
endinterface

// File: rtl/dpr_read_pipe.sv
// ---------------------------------------------------------------------------
// dpr_read_pipe
// Read-side pipeline for one port of the line RAM.
//   clk, rst_n   : clock, asynchronous active-low reset
//   acc_i        : a request was accepted on this edge
//   raw_line_i   : registered array output (loaded on accepted requests)
//   byp_mask_i   : words the other port writes to this address this cycle
//   byp_line_i   : the other port's write line this cycle
//   data_o       : read line (holds when valid_o = 0, zero after reset)
//   valid_o      : read result valid
// ---------------------------------------------------------------------------
module dpr_read_pipe
    import ram_pkg::*;
#(
    parameter int        N            = 32,
    parameter int        WORDSPERLINE = 2,
    parameter bit        OUT_REG      = 1'b0,
    parameter rdw_mode_e RDW_MODE     = RDW_OLD
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           acc_i,
    input  logic [WORDSPERLINE-1:0][N-1:0] raw_line_i,
    input  logic [WORDSPERLINE-1:0]        byp_mask_i,
    input  logic [WORDSPERLINE-1:0][N-1:0] byp_line_i,
    output logic [WORDSPERLINE-1:0][N-1:0] data_o,
    output logic                           valid_o
);
    localparam int LINE_W = N * WORDSPERLINE;

    logic                           v1_q;
    logic                           seen_q;
    logic [WORDSPERLINE-1:0]        byp_mask_q;
    logic [WORDSPERLINE-1:0][N-1:0] byp_line_q;
    logic [LINE_W-1:0]              bit_mask;
    logic [WORDSPERLINE-1:0][N-1:0] line1;

    // The raw array register carries no reset (block RAM output), so seen_q
    // forces the visible line to zero until the first accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            seen_q     <= 1'b0;
            byp_mask_q <= '0;
            byp_line_q <= '0;
        end else begin
            v1_q <= acc_i;
            if (acc_i) begin
                seen_q     <= 1'b1;
                byp_mask_q <= byp_mask_i;
                byp_line_q <= byp_line_i;
            end
        end
    end

    // Bypass only applies in new-data mode; in old-data mode the mask is 0.
    generate
        for (genvar gi = 0; gi < WORDSPERLINE; gi++) begin : g_mask
            assign bit_mask[gi*N +: N] = {N{byp_mask_q[gi] && (RDW_MODE == RDW_NEW)}};
        end
    endgenerate

    assign line1 = seen_q
        ? LINE_W'(merge_line(MERGE_MAX_W'(bit_mask),
                             MERGE_MAX_W'(byp_line_q),
                             MERGE_MAX_W'(raw_line_i)))
        : '0;

    generate
        if (OUT_REG) begin : g_out_reg
            logic                           v2_q;
            logic [WORDSPERLINE-1:0][N-1:0] line2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2_q    <= 1'b0;
                    line2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        line2_q <= line1;
                    end
                end
            end

            assign data_o  = line2_q;
            assign valid_o = v2_q;
        end else begin : g_no_out_reg
            assign data_o  = line1;
            assign valid_o = v1_q;
        end
    endgenerate

endmodule

// File: rtl/dual_port_line_ram.sv
// ---------------------------------------------------------------------------
// dual_port_line_ram
// True dual-port line RAM: each port reads a whole line of WORDSPERLINE
// words and writes any subset of its words. After reset a sweep zeroes the
// array two lines per cycle; ready rises once the sweep is done.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   port1  : access port 1 (wins per-word write collisions)
//   port2  : access port 2
//   ready  : sweep finished, requests accepted
// ---------------------------------------------------------------------------
module dual_port_line_ram
    import ram_pkg::*;
#(
    parameter int        N             = 32,
    parameter int        WORDSPERLINE  = 2,
    parameter int        ADDRESS_WIDTH = 10,
    parameter bit        OUT_REG       = 1'b0,
    parameter rdw_mode_e RDW_MODE      = RDW_OLD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dual_port_line_ram_if.slave   port1,
    dual_port_line_ram_if.slave   port2,
    output logic                  ready
);
    localparam int RAM_DEPTH = 2 ** ADDRESS_WIDTH;

    typedef logic [WORDSPERLINE-1:0][N-1:0] line_t;

    dpr_state_e               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] clr_addr_q, clr_addr_d;

    logic                     acc1, acc2;
    logic                     clearing;
    logic                     same_addr;
    logic [WORDSPERLINE-1:0]  wr_mask1, wr_mask2;
    logic [ADDRESS_WIDTH-1:0] wr_addr1, wr_addr2;
    line_t                    wr_line1, wr_line2;
    logic [WORDSPERLINE-1:0]  byp_mask1, byp_mask2;

    line_t                    mem_q [RAM_DEPTH];
    line_t                    rd_raw1_q, rd_raw2_q;

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + ADDRESS_WIDTH'(2);
                if (clr_addr_q == ADDRESS_WIDTH'(RAM_DEPTH - 2)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign ready    = (state_q == RUN);
    assign clearing = (state_q == CLEAR);
    assign acc1     = ready && port1.en;
    assign acc2     = ready && port2.en;

    // ---------------- write ports ----------------
    // During the sweep both write ports are borrowed to zero an even/odd
    // line pair; clr_addr_q is always even so OR-ing in 1 gives the odd line.
    assign wr_mask1 = clearing ? '1 : (acc1 ? port1.we : '0);
    assign wr_mask2 = clearing ? '1 : (acc2 ? port2.we : '0);
    assign wr_addr1 = clearing ? clr_addr_q : port1.addr;
    assign wr_addr2 = clearing ? (clr_addr_q | ADDRESS_WIDTH'(1)) : port2.addr;
    assign wr_line1 = clearing ? '0 : port1.data_in;
    assign wr_line2 = clearing ? '0 : port2.data_in;

    // Port 1 is applied after port 2 so it takes any word both enable.
    // Reads sample the array before this edge's writes land (read-first).
    always_ff @(posedge clk) begin
        for (int w = 0; w < WORDSPERLINE; w++) begin
            if (wr_mask2[w]) begin
                mem_q[wr_addr2][w] <= wr_line2[w];
            end
            if (wr_mask1[w]) begin
                mem_q[wr_addr1][w] <= wr_line1[w];
            end
        end
        if (acc1) begin
            rd_raw1_q <= mem_q[port1.addr];
        end
        if (acc2) begin
            rd_raw2_q <= mem_q[port2.addr];
        end
    end

    // ---------------- cross-port bypass ----------------
    // A reader sees the other port's written words (new-data mode only;
    // the pipe ignores the mask in old-data mode).
    assign same_addr = (port1.addr == port2.addr);
    assign byp_mask1 = (acc2 && same_addr) ? port2.we : '0;
    assign byp_mask2 = (acc1 && same_addr) ? port1.we : '0;

    dpr_read_pipe #(
        .N            (N),
        .WORDSPERLINE (WORDSPERLINE),
        .OUT_REG      (OUT_REG),
        .RDW_MODE     (RDW_MODE)
    ) u_pipe1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_i      (acc1),
        .raw_line_i (rd_raw1_q),
        .byp_mask_i (byp_mask1),
        .byp_line_i (port2.data_in),
        .data_o     (port1.data_out),
        .valid_o    (port1.rd_valid)
    );

    dpr_read_pipe #(
        .N            (N),
        .WORDSPERLINE (WORDSPERLINE),
        .OUT_REG      (OUT_REG),
        .RDW_MODE     (RDW_MODE)
    ) u_pipe2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_i      (acc2),
        .raw_line_i (rd_raw2_q),
        .byp_mask_i (byp_mask2),
        .byp_line_i (port1.data_in),
        .data_o     (port2.data_out),
        .valid_o    (port2.rd_valid)
    );

endmodule

// File: tb/tb_dual_port_line_ram.sv
// ---------------------------------------------------------------------------
// tb_dual_port_line_ram
// Drives two RAM instances with identical stimulus:
//   dut_a : OUT_REG=0, RDW_OLD
//   dut_b : OUT_REG=1, RDW_NEW
// A line-level model predicts ready / rd_valid / data_out for both every
// cycle; directed steps add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_dual_port_line_ram;
    import ram_pkg::*;

    localparam int N     = 32;
    localparam int WPL   = 2;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int SWEEP = 512;

    typedef logic [WPL-1:0][N-1:0] line_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           en1 = 1'b0, en2 = 1'b0;
    logic [WPL-1:0] we1 = '0, we2 = '0;
    logic [AW-1:0]  addr1 = '0, addr2 = '0;
    line_t          din1 = '0, din2 = '0;

    dual_port_line_ram_if #(.N(N), .WORDSPERLINE(WPL), .ADDRESS_WIDTH(AW)) a1_if ();
    dual_port_line_ram_if #(.N(N), .WORDSPERLINE(WPL), .ADDRESS_WIDTH(AW)) a2_if ();
    dual_port_line_ram_if #(.N(N), .WORDSPERLINE(WPL), .ADDRESS_WIDTH(AW)) b1_if ();
    dual_port_line_ram_if #(.N(N), .WORDSPERLINE(WPL), .ADDRESS_WIDTH(AW)) b2_if ();

    assign a1_if.en = en1;  assign a1_if.we = we1;  assign a1_if.addr = addr1;  assign a1_if.data_in = din1;
    assign b1_if.en = en1;  assign b1_if.we = we1;  assign b1_if.addr = addr1;  assign b1_if.data_in = din1;
    assign a2_if.en = en2;  assign a2_if.we = we2;  assign a2_if.addr = addr2;  assign a2_if.data_in = din2;
    assign b2_if.en = en2;  assign b2_if.we = we2;  assign b2_if.addr = addr2;  assign b2_if.data_in = din2;

    logic rdy_a, rdy_b;

    dual_port_line_ram #(
        .N(N), .WORDSPERLINE(WPL), .ADDRESS_WIDTH(AW), .OUT_REG(1'b0), .RDW_MODE(RDW_OLD)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .port1(a1_if), .port2(a2_if), .ready(rdy_a)
    );

    dual_port_line_ram #(
        .N(N), .WORDSPERLINE(WPL), .ADDRESS_WIDTH(AW), .OUT_REG(1'b1), .RDW_MODE(RDW_NEW)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .port1(b1_if), .port2(b2_if), .ready(rdy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    line_t mdl_mem [DEPTH];
    int    mdl_cyc;
    logic  m_run, m_acc1, m_acc2;
    line_t m_old1, m_old2, m_new1, m_new2;
    // A: result visible one edge after acceptance, old data on collisions.
    logic  exp_a_v1, exp_a_v2;
    line_t exp_a_d1, exp_a_d2;
    // B: result visible two edges after acceptance, merged new data.
    logic  pend_b_v1, pend_b_v2, exp_b_v1, exp_b_v2;
    line_t pend_b_d1, pend_b_d2, exp_b_d1, exp_b_d2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cyc   = 0;
            exp_a_v1  = 1'b0; exp_a_v2  = 1'b0; exp_a_d1  = '0; exp_a_d2  = '0;
            pend_b_v1 = 1'b0; pend_b_v2 = 1'b0; pend_b_d1 = '0; pend_b_d2 = '0;
            exp_b_v1  = 1'b0; exp_b_v2  = 1'b0; exp_b_d1  = '0; exp_b_d2  = '0;
        end else begin
            m_run  = (mdl_cyc >= SWEEP);
            m_acc1 = m_run && en1;
            m_acc2 = m_run && en2;
            m_old1 = mdl_mem[addr1];
            m_old2 = mdl_mem[addr2];
            m_new1 = m_old1;
            m_new2 = m_old2;
            for (int w = 0; w < WPL; w++) begin
                if (m_acc2 && addr1 == addr2 && we2[w]) m_new1[w] = din2[w];
                if (m_acc1 && addr1 == addr2 && we1[w]) m_new2[w] = din1[w];
            end
            exp_b_v1 = pend_b_v1; if (pend_b_v1) exp_b_d1 = pend_b_d1;
            exp_b_v2 = pend_b_v2; if (pend_b_v2) exp_b_d2 = pend_b_d2;
            pend_b_v1 = m_acc1;   if (m_acc1) pend_b_d1 = m_new1;
            pend_b_v2 = m_acc2;   if (m_acc2) pend_b_d2 = m_new2;
            exp_a_v1 = m_acc1;    if (m_acc1) exp_a_d1 = m_old1;
            exp_a_v2 = m_acc2;    if (m_acc2) exp_a_d2 = m_old2;
            for (int w = 0; w < WPL; w++) begin
                if (m_acc2 && we2[w]) mdl_mem[addr2][w] = din2[w];
                if (m_acc1 && we1[w]) mdl_mem[addr1][w] = din1[w];
            end
            if (mdl_cyc == SWEEP - 1) begin
                for (int k = 0; k < DEPTH; k++) mdl_mem[k] = '0;
            end
            if (mdl_cyc < SWEEP + 4) mdl_cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_a", rdy_a, (mdl_cyc >= SWEEP));
            chk("ready_b", rdy_b, (mdl_cyc >= SWEEP));
            chk("a1_valid", a1_if.rd_valid, exp_a_v1);
            chk("a2_valid", a2_if.rd_valid, exp_a_v2);
            chk("a1_data", a1_if.data_out, exp_a_d1);
            chk("a2_data", a2_if.data_out, exp_a_d2);
            chk("b1_valid", b1_if.rd_valid, exp_b_v1);
            chk("b2_valid", b2_if.rd_valid, exp_b_v2);
            chk("b1_data", b1_if.data_out, exp_b_d1);
            chk("b2_data", b2_if.data_out, exp_b_d2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic e1, input logic [WPL-1:0] w1, input logic [AW-1:0] a1, input line_t d1,
                         input logic e2, input logic [WPL-1:0] w2, input logic [AW-1:0] a2, input line_t d2);
        en1 = e1; we1 = w1; addr1 = a1; din1 = d1;
        en2 = e2; we2 = w2; addr2 = a2; din2 = d2;
        @(negedge clk);
    endtask

    task automatic idle();
        en1 = 1'b0; en2 = 1'b0; we1 = '0; we2 = '0;
        @(negedge clk);
    endtask

    // Counts negedges until ready; inputs are idle unless pulse is set.
    task automatic sweep_len(input string name, input bit pulse);
        int n;
        n = 0;
        while (rdy_a !== 1'b1 && n < 2000) begin
            en1 = pulse && n[0];
            en2 = pulse && !n[0];
            addr1 = n[AW-1:0];
            addr2 = n[AW-1:0];
            @(negedge clk);
            n++;
        end
        en1 = 1'b0; en2 = 1'b0;
        chk(name, 64'(n), 64'(SWEEP));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t ln;
        repeat (2) @(negedge clk);
        chk("rst_ready", rdy_a, 0);
        chk("rst_a1_valid", a1_if.rd_valid, 0);
        chk("rst_a2_data", a2_if.data_out, 0);
        chk("rst_b2_valid", b2_if.rd_valid, 0);
        rst_n = 1'b1;

        // Partial sweep, then asynchronous reset at sweep cycle 100.
        repeat (100) @(negedge clk);
        chk("sweep100_ready", rdy_a, 0);
        #2 rst_n = 1'b0;
        #1 chk("midsweep_rst_ready", rdy_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_len("sweep_len_with_en_pulses", 1'b1);

        // First read after the sweep.
        drive(1'b1, 2'b00, 10'h3FF, '0, 1'b0, 2'b00, '0, '0);
        chk("rd3ff_a1_valid", a1_if.rd_valid, 1);
        chk("rd3ff_a1_data", a1_if.data_out, 0);
        idle();
        chk("rd3ff_b1_valid", b1_if.rd_valid, 1);

        // Masked write to line 5.
        drive(1'b1, 2'b11, 10'd5, {32'hBBBB_BBBB, 32'hAAAA_AAAA}, 1'b0, 2'b00, '0, '0);
        drive(1'b1, 2'b01, 10'd5, {32'hDEAD_BEEF, 32'h1234_5678}, 1'b0, 2'b00, '0, '0);
        chk("line5_read_first", a1_if.data_out, {32'hBBBB_BBBB, 32'hAAAA_AAAA});
        drive(1'b1, 2'b00, 10'd5, '0, 1'b1, 2'b00, 10'd5, '0);
        chk("line5_masked_p1", a1_if.data_out, {32'hBBBB_BBBB, 32'h1234_5678});
        chk("line5_masked_p2", a2_if.data_out, {32'hBBBB_BBBB, 32'h1234_5678});

        // Both ports write line 7; port 1 owns word 0.
        drive(1'b1, 2'b01, 10'd7, {32'h0, 32'h1}, 1'b1, 2'b11, 10'd7, {32'h3, 32'h2});
        drive(1'b1, 2'b00, 10'd7, '0, 1'b1, 2'b00, 10'd7, '0);
        chk("line7_collision", a1_if.data_out, {32'h3, 32'h1});
        idle();
        idle();

        // Cross-port read during write on line 9.
        drive(1'b1, 2'b11, 10'd9, {32'hFF, 32'hFF}, 1'b1, 2'b00, 10'd9, '0);
        chk("rdw_old_a2", a2_if.data_out, 0);
        chk("rdw_b2_not_yet", b2_if.rd_valid, 0);
        idle();
        chk("rdw_b2_valid", b2_if.rd_valid, 1);
        chk("rdw_new_b2", b2_if.data_out, {32'hFF, 32'hFF});
        chk("a2_hold_valid", a2_if.rd_valid, 0);
        chk("a2_hold_data", a2_if.data_out, 0);

        // Fill lines 0..15, then stream reads on both ports.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'b11, AW'(i), {32'hC000_0000 | 32'(i), 32'hD000_0000 | 32'(i)},
                  1'b0, 2'b00, '0, '0);
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'b00, AW'(i), '0, 1'b1, 2'b00, AW'(i), '0);
            ln = {32'hC000_0000 | 32'(i), 32'hD000_0000 | 32'(i)};
            chk("stream_a1_valid", a1_if.rd_valid, 1);
            chk("stream_a1_data", a1_if.data_out, ln);
            chk("stream_a2_data", a2_if.data_out, ln);
            if (i > 0) begin
                ln = {32'hC000_0000 | 32'(i - 1), 32'hD000_0000 | 32'(i - 1)};
                chk("stream_b1_valid", b1_if.rd_valid, 1);
                chk("stream_b2_data", b2_if.data_out, ln);
            end
        end
        idle();
        chk("stream_b1_last", b1_if.data_out, {32'hC000_000F, 32'hD000_000F});

        // Reset during RUN with reads in flight, then a full idle sweep.
        en1 = 1'b1; addr1 = 10'd5; we1 = '0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        en1 = 1'b0;
        #1;
        chk("runrst_ready", rdy_a, 0);
        chk("runrst_a1_valid", a1_if.rd_valid, 0);
        chk("runrst_b1_valid", b1_if.rd_valid, 0);
        chk("runrst_a1_data", a1_if.data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_len("sweep_len_idle", 1'b0);

        // Sweep must have cleared previously written lines.
        drive(1'b1, 2'b00, 10'd5, '0, 1'b1, 2'b00, 10'h3FF, '0);
        chk("cleared_line5", a1_if.data_out, 0);
        chk("cleared_3ff_valid", a2_if.rd_valid, 1);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
